// File: rtl/mdu_issue_arbiter_pkg.sv
// Payload types shared by the MDU issue arbiter, its interface and its users.
package mdu_issue_arbiter_pkg;

  typedef struct packed {
    logic [2:0]       op;
    logic [1:0][31:0] data;
    logic [4:0]       reg_id;
  } mdu_i_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  reg_id;
  } mdu_o_t;

endpackage

// File: rtl/mdu_issue_arbiter_if.sv
// Request, issue, result and return channels around the MDU issue arbiter.
interface mdu_issue_arbiter_if;
  import mdu_issue_arbiter_pkg::*;

  logic   flush;
  mdu_i_t req0_i;
  mdu_i_t req1_i;
  logic   req0_valid_i;
  logic   req1_valid_i;
  logic   req0_ready_o;
  logic   req1_ready_o;
  mdu_i_t mdu_req_o;
  logic   mdu_valid_o;
  logic   mdu_ready_i;
  mdu_o_t mdu_res_i;
  logic   mdu_valid_i;
  logic   mdu_ready_o;
  mdu_o_t res0_o;
  mdu_o_t res1_o;
  logic   res0_valid_o;
  logic   res1_valid_o;
  logic   res0_ready_i;
  logic   res1_ready_i;
  logic   err_o;

  modport slave (
    input  flush, req0_i, req1_i, req0_valid_i, req1_valid_i,
    output req0_ready_o, req1_ready_o, mdu_req_o, mdu_valid_o,
    input  mdu_ready_i, mdu_res_i, mdu_valid_i,
    output mdu_ready_o, res0_o, res1_o, res0_valid_o, res1_valid_o,
    input  res0_ready_i, res1_ready_i,
    output err_o
  );

  modport master (
    output flush, req0_i, req1_i, req0_valid_i, req1_valid_i,
    input  req0_ready_o, req1_ready_o, mdu_req_o, mdu_valid_o,
    output mdu_ready_i, mdu_res_i, mdu_valid_i,
    input  mdu_ready_o, res0_o, res1_o, res0_valid_o, res1_valid_o,
    output res0_ready_i, res1_ready_i,
    input  err_o
  );

endinterface

// File: rtl/mdu_issue_arbiter.sv
// Two-requester round-robin issue arbiter for a shared multiplier; a tag FIFO
// remembers the source of each in-flight op so results return in issue order.
module mdu_issue_arbiter #(
  parameter int unsigned TAG_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  mdu_issue_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(TAG_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          rr;
  logic          err;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          tags [TAG_DEPTH];

  logic grant_valid;
  logic grant_idx;
  logic full;
  logic empty;
  logic head;
  logic issue;
  logic pop;
  logic spurious;

  always_comb begin
    grant_valid = bus.req0_valid_i | bus.req1_valid_i;
    // With a single valid requester the index is simply whether it is req1.
    grant_idx   = (bus.req0_valid_i & bus.req1_valid_i) ? rr : bus.req1_valid_i;
    full        = (count == CW'(TAG_DEPTH));
    empty       = (count == '0);
    head        = tags[rd_ptr];

    bus.mdu_req_o    = grant_idx ? bus.req1_i : bus.req0_i;
    bus.mdu_valid_o  = !rst && grant_valid && !full && !bus.flush;
    issue            = bus.mdu_valid_o && bus.mdu_ready_i;
    bus.req0_ready_o = issue && !grant_idx;
    bus.req1_ready_o = issue && grant_idx;

    bus.res0_o       = bus.mdu_res_i;
    bus.res1_o       = bus.mdu_res_i;
    bus.res0_valid_o = 1'b0;
    bus.res1_valid_o = 1'b0;
    bus.mdu_ready_o  = 1'b1;
    bus.err_o        = err;
    pop              = 1'b0;
    spurious         = 1'b0;

    // Flush and empty both sink results; only the empty case is a protocol error.
    if (!rst && !bus.flush) begin
      if (empty) begin
        spurious = bus.mdu_valid_i;
      end else begin
        bus.mdu_ready_o  = head ? bus.res1_ready_i : bus.res0_ready_i;
        bus.res0_valid_o = bus.mdu_valid_i && !head;
        bus.res1_valid_o = bus.mdu_valid_i && head;
        pop              = bus.mdu_valid_i && bus.mdu_ready_o;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr     <= 1'b0;
      err    <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        tags[i] <= 1'b0;
      end
    end else begin
      if (spurious) begin
        err <= 1'b1;
      end
      if (bus.flush) begin
        rr     <= 1'b0;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (issue) begin
          tags[wr_ptr] <= grant_idx;
          wr_ptr       <= wr_ptr + AW'(1);
          rr           <= ~grant_idx;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (issue && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !issue) begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_issue_arbiter.sv
// Directed bench for mdu_issue_arbiter with hand-derived expectations.
module tb_mdu_issue_arbiter;
  import mdu_issue_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_issue_arbiter_if bus ();

  mdu_issue_arbiter #(.TAG_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned n_checks;
  int unsigned n_fail;

  logic [4:0] id0, id1;
  logic       exp_g;
  logic       pv  [3];
  logic [4:0] pid [3];
  logic [5:0] expq [$];
  logic [5:0] expv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.flush        = 1'b0;
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    bus.req0_i       = '0;
    bus.req1_i       = '0;
    bus.mdu_ready_i  = 1'b1;
    bus.mdu_valid_i  = 1'b0;
    bus.mdu_res_i    = '0;
    bus.res0_ready_i = 1'b1;
    bus.res1_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drive_res(input logic [4:0] id);
    bus.mdu_valid_i      = 1'b1;
    bus.mdu_res_i.reg_id = id;
    bus.mdu_res_i.result = {27'd0, id};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Outputs gated during reset even with every valid asserted
    idle();
    rst = 1'b1;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    bus.mdu_valid_i  = 1'b1;
    settle();
    check("rst_mdu_valid", bus.mdu_valid_o, 0);
    check("rst_req0_ready", bus.req0_ready_o, 0);
    check("rst_req1_ready", bus.req1_ready_o, 0);
    check("rst_res_valid", {bus.res1_valid_o, bus.res0_valid_o}, 0);
    check("rst_mdu_ready", bus.mdu_ready_o, 1);
    step();
    check("rst_err", bus.err_o, 0);
    check("rst_count", dut.count, 0);
    idle();
    rst = 1'b0;
    step();

    // Both requesters continuously valid, latency-3 multiplier
    id0 = 5'd0; id1 = 5'd16; exp_g = 1'b0;
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pid[i] = '0; end
    for (int c = 0; c < 20; c++) begin
      bus.req0_valid_i     = (c < 14);
      bus.req1_valid_i     = (c < 14);
      bus.req0_i.reg_id    = id0;
      bus.req1_i.reg_id    = id1;
      bus.mdu_valid_i      = pv[2];
      bus.mdu_res_i.reg_id = pid[2];
      bus.mdu_res_i.result = {27'd0, pid[2]};
      settle();
      if (c < 14) begin
        check("alt_grant0", bus.req0_ready_o, !exp_g);
        check("alt_grant1", bus.req1_ready_o, exp_g);
        check("alt_payload", bus.mdu_req_o.reg_id, exp_g ? id1 : id0);
      end
      if (pv[2]) begin
        expv = expq.pop_front();
        check("alt_res0_valid", bus.res0_valid_o, !expv[5]);
        check("alt_res1_valid", bus.res1_valid_o, expv[5]);
        check("alt_res_id", expv[5] ? bus.res1_o.reg_id : bus.res0_o.reg_id, expv[4:0]);
      end else begin
        check("alt_no_res", {bus.res1_valid_o, bus.res0_valid_o}, 0);
      end
      pv[2] = pv[1]; pid[2] = pid[1];
      pv[1] = pv[0]; pid[1] = pid[0];
      pv[0] = (c < 14); pid[0] = exp_g ? id1 : id0;
      if (c < 14) begin
        expq.push_back({exp_g, pid[0]});
        if (exp_g) id1++; else id0++;
        exp_g = ~exp_g;
      end
      step();
    end
    check("alt_drained", expq.size(), 0);
    check("alt_count", dut.count, 0);
    check("alt_err", bus.err_o, 0);

    // Lone req1 streak, then lone req0 granted at once
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.req1_valid_i  = 1'b1;
      bus.req1_i.reg_id = 5'(c);
      if (c > 0) drive_res(5'(c - 1));
      settle();
      check("solo1_ready1", bus.req1_ready_o, 1);
      check("solo1_ready0", bus.req0_ready_o, 0);
      if (c > 0) begin
        check("solo1_res_valid", bus.res1_valid_o, 1);
        check("solo1_res_id", bus.res1_o.reg_id, c - 1);
      end
      step();
      check("solo1_rr", dut.rr, 0);
    end
    bus.req1_valid_i  = 1'b0;
    bus.req0_valid_i  = 1'b1;
    bus.req0_i.reg_id = 5'd9;
    drive_res(5'd5);
    settle();
    check("solo0_ready0", bus.req0_ready_o, 1);
    check("solo0_res1_valid", bus.res1_valid_o, 1);
    step();
    bus.req0_valid_i = 1'b0;
    drive_res(5'd9);
    settle();
    check("solo0_res0_valid", bus.res0_valid_o, 1);
    check("solo0_res0_id", bus.res0_o.reg_id, 9);
    step();
    check("solo_err", bus.err_o, 0);

    // Full tag FIFO blocks issue; pop at full frees a slot only next cycle
    do_reset();
    bus.res0_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.req0_valid_i  = 1'b1;
      bus.req0_i.reg_id = 5'(c);
      settle();
      check("fill_ready0", bus.req0_ready_o, 1);
      step();
    end
    check("full_count", dut.count, 4);
    bus.req0_i.reg_id = 5'd4;
    settle();
    check("full_ready0", bus.req0_ready_o, 0);
    check("full_mdu_valid", bus.mdu_valid_o, 0);
    drive_res(5'd0);
    settle();
    check("full_res0_valid", bus.res0_valid_o, 1);
    check("full_mdu_ready_bp", bus.mdu_ready_o, 0);
    step();
    check("full_count_held", dut.count, 4);
    bus.res0_ready_i = 1'b1;
    settle();
    check("full_mdu_ready", bus.mdu_ready_o, 1);
    check("full_pop_blocks", bus.req0_ready_o, 0);
    step();
    check("full_count_pop", dut.count, 3);
    bus.mdu_valid_i = 1'b0;
    settle();
    check("full_resume", bus.req0_ready_o, 1);
    step();
    check("full_count_refill", dut.count, 4);

    // Flush with two ops in flight
    do_reset();
    bus.req1_valid_i  = 1'b1;
    bus.req1_i.reg_id = 5'd1;
    settle();
    check("fl_issue_a", bus.req1_ready_o, 1);
    step();
    bus.req1_i.reg_id = 5'd2;
    settle();
    check("fl_issue_b", bus.req1_ready_o, 1);
    step();
    bus.req1_valid_i  = 1'b0;
    bus.req0_valid_i  = 1'b1;
    bus.req0_i.reg_id = 5'd3;
    drive_res(5'd1);
    settle();
    check("fl_issue_c", bus.req0_ready_o, 1);
    check("fl_res1_valid", bus.res1_valid_o, 1);
    check("fl_res1_id", bus.res1_o.reg_id, 1);
    step();
    check("fl_count_pushpop", dut.count, 2);
    check("fl_rr_before", dut.rr, 1);
    bus.flush = 1'b1;
    drive_res(5'd2);
    settle();
    check("fl_mdu_valid", bus.mdu_valid_o, 0);
    check("fl_req0_ready", bus.req0_ready_o, 0);
    check("fl_res_valid", {bus.res1_valid_o, bus.res0_valid_o}, 0);
    check("fl_mdu_ready", bus.mdu_ready_o, 1);
    step();
    check("fl_count", dut.count, 0);
    check("fl_rr", dut.rr, 0);
    check("fl_err_clear", bus.err_o, 0);
    bus.flush        = 1'b0;
    bus.req0_valid_i = 1'b0;
    drive_res(5'd2);
    settle();
    check("fl_drop_res", {bus.res1_valid_o, bus.res0_valid_o}, 0);
    check("fl_drop_ready", bus.mdu_ready_o, 1);
    step();
    check("fl_err_set", bus.err_o, 1);
    drive_res(5'd3);
    settle();
    check("fl_drop_res2", {bus.res1_valid_o, bus.res0_valid_o}, 0);
    step();
    check("fl_err_sticky", bus.err_o, 1);

    // Simultaneous issue and result at count 2 keeps order
    do_reset();
    bus.req0_valid_i  = 1'b1;
    bus.req0_i.reg_id = 5'd10;
    step();
    bus.req0_valid_i  = 1'b0;
    bus.req1_valid_i  = 1'b1;
    bus.req1_i.reg_id = 5'd11;
    step();
    check("ord_count2", dut.count, 2);
    bus.req1_valid_i  = 1'b0;
    bus.req0_valid_i  = 1'b1;
    bus.req0_i.reg_id = 5'd12;
    drive_res(5'd10);
    settle();
    check("ord_issue", bus.req0_ready_o, 1);
    check("ord_res_a_valid", bus.res0_valid_o, 1);
    check("ord_res_a_id", bus.res0_o.reg_id, 10);
    step();
    check("ord_count_same", dut.count, 2);
    bus.req0_valid_i = 1'b0;
    drive_res(5'd11);
    settle();
    check("ord_res_b", {bus.res1_valid_o, bus.res0_valid_o}, 2'b10);
    check("ord_res_b_id", bus.res1_o.reg_id, 11);
    step();
    drive_res(5'd12);
    settle();
    check("ord_res_c", {bus.res1_valid_o, bus.res0_valid_o}, 2'b01);
    check("ord_res_c_id", bus.res0_o.reg_id, 12);
    step();
    check("ord_count_end", dut.count, 0);
    check("ord_err", bus.err_o, 0);

    // Spurious result after reset: sticky through flush, cleared by reset
    do_reset();
    drive_res(5'd7);
    settle();
    check("sp_mdu_ready", bus.mdu_ready_o, 1);
    check("sp_res_valid", {bus.res1_valid_o, bus.res0_valid_o}, 0);
    check("sp_err_before", bus.err_o, 0);
    step();
    idle();
    check("sp_err_set", bus.err_o, 1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("sp_err_flush", bus.err_o, 1);
    step();
    check("sp_err_hold", bus.err_o, 1);
    rst = 1'b1;
    settle();
    check("sp_err_rst", bus.err_o, 0);
    rst = 1'b0;

    // Reset mid-operation discards tracked tags
    do_reset();
    bus.req0_valid_i  = 1'b1;
    bus.req0_i.reg_id = 5'd1;
    step();
    bus.req0_i.reg_id = 5'd2;
    step();
    check("mid_count", dut.count, 2);
    idle();
    rst = 1'b1;
    settle();
    check("mid_count_rst", dut.count, 0);
    step();
    rst = 1'b0;
    step();
    drive_res(5'd1);
    settle();
    check("mid_no_res", {bus.res1_valid_o, bus.res0_valid_o}, 0);
    step();
    check("mid_err", bus.err_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_issue_arbiter.md
MDU_ISSUE_ARBITER -- requirements
Module: mdu_issue_arbiter

Interface
REQ-001 Parameter: TAG_DEPTH, default 4, number of in-flight multiplies tracked (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  synchronous pipeline flush.
REQ-005 req0_i / req1_i  input  mdu_i_t  operation from requester 0 / 1 (op, data[0..1], reg_id).
REQ-006 req0_valid_i / req1_valid_i  input  1  request valid.
REQ-007 req0_ready_o / req1_ready_o  output  1  request accepted this cycle when valid also high.
REQ-008 mdu_req_o  output  mdu_i_t  payload of the granted requester, to the multiplier.
REQ-009 mdu_valid_o  output  1 / mdu_ready_i  input  1  multiplier issue handshake.
REQ-010 mdu_res_i  input  mdu_o_t / mdu_valid_i  input  1 / mdu_ready_o  output  1  multiplier result handshake.
REQ-011 res0_o / res1_o  output  mdu_o_t, res0_valid_o / res1_valid_o  output  1, res0_ready_i / res1_ready_i  input  1  result return to each requester.
REQ-012 err_o  output  1  sticky protocol-error flag.

Function
REQ-013 Grant is combinational: single valid requester wins; both valid -> requester selected by round-robin bit rr wins.
REQ-014 Issue condition: a grant exists, mdu_ready_i=1, tag FIFO not full, flush=0.
REQ-015 mdu_valid_o = grant exists && tag FIFO not full && flush=0; mdu_req_o = granted payload, passed unmodified (no register).
REQ-016 reqN_ready_o = 1 only for the granted requester when issue condition holds; loser's ready = 0.
REQ-017 On issue, rr <= index of non-granted requester; rr unchanged when no issue.
REQ-018 On issue, source index (1 bit) pushed into tag FIFO (TAG_DEPTH entries, count 0..TAG_DEPTH).
REQ-019 Result routing: when mdu_valid_i=1 and FIFO non-empty, head tag H selects destination; resH_valid_o=1, resH_o=mdu_res_i, other res valid=0.
REQ-020 mdu_ready_o = resH_ready_i when FIFO non-empty; result handshake pops FIFO head.
REQ-021 Non-selected requester's res_o may hold any value; only valid qualifies it.
REQ-022 Simultaneous push and pop: count unchanged, order preserved, legal at full (pop frees slot only next cycle; full blocks issue in that cycle).
REQ-023 mdu_valid_i=1 with FIFO empty: result dropped, mdu_ready_o=1, no res valid, err_o set to 1 next edge.
REQ-024 err_o stays 1 until rst; flush does not clear it.
REQ-025 flush=1: FIFO count and pointers cleared next edge, rr cleared to 0, all reqN_ready_o, resN_valid_o and mdu_valid_o forced 0 in that cycle, mdu_ready_o=1 (results in flight discarded).
REQ-026 Ordering: results returned strictly in issue order; multiplier latency irrelevant to correctness.

Reset
REQ-027 rst=1 asynchronously: FIFO empty, pointers 0, rr=0 (requester 0 preferred), err_o=0.
REQ-028 During reset all valid/ready outputs read 0 except mdu_ready_o which reads 1; state changes resume on first edge after deassertion.
REQ-029 Reset asserted mid-operation discards all tracked tags; no result routed after deassertion until a new issue.

Verification
REQ-030 Both requesters valid continuously, mdu_ready_i=1, fixed-latency-3 model: grants alternate 0,1,0,1; results return to res0,res1,res0,res1 with matching reg_id.
REQ-031 Only req1 valid for 6 cycles -> 6 consecutive grants to req1, rr=0 after each; req0 then raised alone -> granted immediately.
REQ-032 res0_ready_i=0, issue 4 ops from req0 with TAG_DEPTH=4 -> 5th request sees req0_ready_o=0; raise res0_ready_i -> pops one, issue resumes next cycle.
REQ-033 Issue 3 ops, assert flush one cycle while 2 in flight -> count=0, later mdu_valid_i pulses dropped with err_o=1, no resN_valid_o.
REQ-034 Spurious mdu_valid_i after reset (FIFO empty) -> mdu_ready_o=1, err_o=1 next cycle, remains 1 through flush, cleared only by rst.
REQ-035 Simultaneous issue and result handshake at count=2 -> count stays 2, subsequent results still in issue order.
